// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/response port plus the
// valid/ready output register toward decode.
// master = fetch unit side, slave = memory/decode side.
interface fetch_unit_if;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic [31:0] ir_o;
   logic [31:0] pc_o;
   logic        ir_valid_o;
   logic        ir_ready_i;

   modport master (
      output imem_req_o, imem_addr_o, ir_o, pc_o, ir_valid_o,
      input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, ir_ready_i
   );

   modport slave (
      input  imem_req_o, imem_addr_o, ir_o, pc_o, ir_valid_o,
      output imem_gnt_i, imem_rvalid_i, imem_rdata_i, ir_ready_i
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, keeps at most one imem request
// outstanding and hands {ir, pc} pairs to decode through a valid/ready register.
// Optional build macro FETCH_MISALIGN_CHECK_EN adds fetch_misalign_o and a FAULT
// state entered on a misaligned redirect target.
//
// state | meaning
// IDLE  | out of reset, waiting for control to leave SEL_PC_NONE
// REQ   | presenting pc_q to imem (gated by stall / full output)
// WAIT  | request granted, waiting for its single response
// HOLD  | response parked in hold buffer behind a full output register
// FAULT | misaligned redirect target seen, no fetching (optional build only)
module fetch_unit #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter logic [31:0] NOP_INSN     = 32'h0000_0013,
   parameter int          SEL_PC_WIDTH = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    fetch_stall_i,
   input  logic [SEL_PC_WIDTH-1:0] pc_sel_i,
   input  logic                    br_taken_i,
   input  logic [31:0]             next_pc_i,
`ifdef FETCH_MISALIGN_CHECK_EN
   output logic                    fetch_misalign_o,
`endif
   fetch_unit_if.master            bus
);

   localparam logic [SEL_PC_WIDTH-1:0] SEL_PC_NONE   = SEL_PC_WIDTH'(0);
   localparam logic [SEL_PC_WIDTH-1:0] SEL_PC_JUMP   = SEL_PC_WIDTH'(2);
   localparam logic [SEL_PC_WIDTH-1:0] SEL_PC_BRANCH = SEL_PC_WIDTH'(3);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_HOLD  = 3'd3
`ifdef FETCH_MISALIGN_CHECK_EN
      , S_FAULT = 3'd4
`endif
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] pco_q, pco_d;
   logic        valid_q, valid_d;
   logic        kill_q, kill_d;
   logic [31:0] hold_ir_q, hold_ir_d;
   logic [31:0] hold_pc_q, hold_pc_d;
   logic        redirect, handoff, req, grant, rvalid;
   logic [31:0] target;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic        misalign_q, misalign_d;
   logic        misaligned;

   assign target     = next_pc_i;
   assign misaligned = redirect & (next_pc_i[1:0] != 2'b00);
   assign fetch_misalign_o = misalign_q;
`else
   assign target     = next_pc_i & 32'hFFFF_FFFC;
`endif

   assign redirect = (pc_sel_i == SEL_PC_JUMP) | ((pc_sel_i == SEL_PC_BRANCH) & br_taken_i);
   assign handoff  = valid_q & bus.ir_ready_i;
   assign req      = (state_q == S_REQ) & ~fetch_stall_i & (~valid_q | bus.ir_ready_i);
   assign grant    = req & bus.imem_gnt_i;
   assign rvalid   = bus.imem_rvalid_i;

   assign bus.imem_req_o  = req;
   assign bus.imem_addr_o = pc_q;
   assign bus.ir_o        = valid_q ? ir_q : NOP_INSN;
   assign bus.pc_o        = pco_q;
   assign bus.ir_valid_o  = valid_q;

   // State register and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         ir_q       <= NOP_INSN;
         pco_q      <= 32'h0;
         valid_q    <= 1'b0;
         kill_q     <= 1'b0;
         hold_ir_q  <= NOP_INSN;
         hold_pc_q  <= 32'h0;
`ifdef FETCH_MISALIGN_CHECK_EN
         misalign_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         pco_q      <= pco_d;
         valid_q    <= valid_d;
         kill_q     <= kill_d;
         hold_ir_q  <= hold_ir_d;
         hold_pc_q  <= hold_pc_d;
`ifdef FETCH_MISALIGN_CHECK_EN
         misalign_q <= misalign_d;
`endif
      end
   end

   // Next-state logic; redirect is applied last so it overrides everything else.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      pco_d      = pco_q;
      valid_d    = valid_q;
      kill_d     = kill_q;
      hold_ir_d  = hold_ir_q;
      hold_pc_d  = hold_pc_q;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_d = misalign_q;
`endif

      if (handoff) valid_d = 1'b0;

      case (state_q)
         S_IDLE: if (pc_sel_i != SEL_PC_NONE) state_d = S_REQ;
         S_REQ:  if (grant) state_d = S_WAIT;
         S_WAIT: begin
            if (rvalid) begin
               if (kill_q) begin
                  kill_d  = 1'b0;
                  state_d = S_REQ;
               end else if (!valid_q || handoff) begin
                  ir_d    = bus.imem_rdata_i;
                  pco_d   = pc_q;
                  valid_d = 1'b1;
                  pc_d    = pc_q + 32'd4;
                  state_d = S_REQ;
               end else begin
                  hold_ir_d = bus.imem_rdata_i;
                  hold_pc_d = pc_q;
                  pc_d      = pc_q + 32'd4;
                  state_d   = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (handoff) begin
               ir_d    = hold_ir_q;
               pco_d   = hold_pc_q;
               valid_d = 1'b1;
               state_d = S_REQ;
            end
         end
`ifdef FETCH_MISALIGN_CHECK_EN
         // A response still owed from before the fault is swallowed here.
         S_FAULT: if (rvalid) kill_d = 1'b0;
`endif
         default: state_d = S_IDLE;
      endcase

      if (redirect) begin
         pc_d    = target;
         valid_d = 1'b0;
         ir_d    = NOP_INSN;
         kill_d  = 1'b0;
         if (state_q == S_WAIT) begin
            if (rvalid) begin
               state_d = S_REQ;
            end else begin
               state_d = S_WAIT;
               kill_d  = 1'b1;
            end
         end
`ifdef FETCH_MISALIGN_CHECK_EN
         // Leaving FAULT with a stale response still owed: wait it out as killed.
         else if (state_q == S_FAULT) begin
            if (kill_q && !rvalid) begin
               state_d = S_WAIT;
               kill_d  = 1'b1;
            end else begin
               state_d = S_REQ;
            end
         end
`endif
         else if (grant) begin
            state_d = S_WAIT;
            kill_d  = 1'b1;
         end else begin
            state_d = S_REQ;
         end
`ifdef FETCH_MISALIGN_CHECK_EN
         misalign_d = misaligned;
         if (misaligned) state_d = S_FAULT;
`endif
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle table for start-up, scoreboard of expected
// {pc, ir} handoffs, and directed sequences for stall, redirect and reset.
module tb_fetch_unit;
   localparam logic [1:0]  SEL_NONE   = 2'd0;
   localparam logic [1:0]  SEL_ADD4   = 2'd1;
   localparam logic [1:0]  SEL_JUMP   = 2'd2;
   localparam logic [1:0]  SEL_BRANCH = 2'd3;
   localparam logic [31:0] NOP        = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        br_taken = 1'b0;
   logic [1:0]  pc_sel = SEL_NONE;
   logic [31:0] next_pc = 32'h0;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic        misalign, misalign2;
`endif

   fetch_unit_if if0();
   fetch_unit_if if1();

   always #5 clk = ~clk;

   fetch_unit u_dut (
      .clk(clk), .rst(rst), .fetch_stall_i(stall), .pc_sel_i(pc_sel),
      .br_taken_i(br_taken), .next_pc_i(next_pc),
`ifdef FETCH_MISALIGN_CHECK_EN
      .fetch_misalign_o(misalign),
`endif
      .bus(if0)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut2 (
      .clk(clk), .rst(rst), .fetch_stall_i(stall), .pc_sel_i(pc_sel),
      .br_taken_i(br_taken), .next_pc_i(next_pc),
`ifdef FETCH_MISALIGN_CHECK_EN
      .fetch_misalign_o(misalign2),
`endif
      .bus(if1)
   );

   assign if1.imem_gnt_i = if0.imem_gnt_i;
   assign if1.ir_ready_i = if0.ir_ready_i;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          lat = 1;
   logic [31:0] exp_q[$];
   logic [31:0] glog[$];
   logic [31:0] glog2[$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hA5C3_0F00;
   endfunction

   // Instruction memory for u_dut: one response per grant after `lat` cycles.
   int          m_cnt;
   logic        m_busy;
   logic [31:0] m_addr;
   always @(posedge clk) begin
      if (rst) begin
         m_busy <= 1'b0;
         m_cnt <= 0;
         if0.imem_rvalid_i <= 1'b0;
      end else begin
         if0.imem_rvalid_i <= 1'b0;
         if (m_busy) begin
            if (m_cnt == 1) begin
               if0.imem_rvalid_i <= 1'b1;
               if0.imem_rdata_i <= mem_word(m_addr);
               m_busy <= 1'b0;
            end else begin
               m_cnt <= m_cnt - 1;
            end
         end else if (if0.imem_req_o && if0.imem_gnt_i) begin
            if (lat == 1) begin
               if0.imem_rvalid_i <= 1'b1;
               if0.imem_rdata_i <= mem_word(if0.imem_addr_o);
            end else begin
               m_busy <= 1'b1;
               m_cnt <= lat - 1;
               m_addr <= if0.imem_addr_o;
            end
         end
      end
   end

   // Memory for u_dut2: fixed 1-cycle latency.
   always @(posedge clk) begin
      if (rst) begin
         if1.imem_rvalid_i <= 1'b0;
      end else begin
         if1.imem_rvalid_i <= if1.imem_req_o & if1.imem_gnt_i;
         if (if1.imem_req_o && if1.imem_gnt_i) if1.imem_rdata_i <= mem_word(if1.imem_addr_o);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Once per cycle at negedge: log grants and score handoffs.
   task automatic smp();
      logic [31:0] e;
      @(negedge clk);
      if (!rst) begin
         if (if0.imem_req_o && if0.imem_gnt_i) glog.push_back(if0.imem_addr_o);
         if (if1.imem_req_o && if1.imem_gnt_i) glog2.push_back(if1.imem_addr_o);
         if (if0.ir_valid_o && if0.ir_ready_i) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_handoff: got pc %h expected none", if0.pc_o);
            end else begin
               e = exp_q.pop_front();
               chk("handoff_pc", if0.pc_o, e);
               chk("handoff_ir", if0.ir_o, mem_word(e));
            end
         end
      end
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      pc_sel = SEL_NONE;
      stall = 1'b0;
      br_taken = 1'b0;
      next_pc = 32'h0;
      if0.imem_gnt_i = 1'b1;
      if0.ir_ready_i = 1'b1;
      lat = 1;
      cyc();
      cyc();
      rst = 1'b0;
      glog.delete();
      glog2.delete();
      exp_q.delete();
      chk("rst_req", 32'(if0.imem_req_o), 32'h0);
      chk("rst_addr", if0.imem_addr_o, 32'h0);
      chk("rst_valid", 32'(if0.ir_valid_o), 32'h0);
      chk("rst_ir", if0.ir_o, NOP);
      chk("rst_pc", if0.pc_o, 32'h0);
      chk("rst_addr2", if1.imem_addr_o, 32'hFFFF_FFFC);
   endtask

   task automatic push_exp(input logic [31:0] start, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
   endtask

   task automatic wait_grant(input logic [31:0] exp_addr, input string name);
      int n0 = glog.size();
      int n = 0;
      while (glog.size() == n0 && n < 100) begin
         smp();
         n++;
         if (glog.size() == n0) cyc();
      end
      if (glog.size() == n0) chk({name, "_timeout"}, 32'h0, 32'h1);
      else chk(name, glog[n0], exp_addr);
      cyc();
   endtask

   task automatic wait_drain(input string name);
      for (int n = 0; n < 300 && exp_q.size() != 0; n++) begin
         smp();
         cyc();
      end
      chk(name, 32'(exp_q.size()), 32'h0);
      if0.ir_ready_i = 1'b0;
   endtask

   typedef struct {
      logic [1:0]  sel;
      logic        req;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] pc;
   } vec_t;

   vec_t tbl[9];

   initial begin
      logic seen;
      int   n0;

      tbl[0] = '{SEL_NONE, 1'b0, 32'h0, 1'b0, 32'h0};
      tbl[1] = '{SEL_ADD4, 1'b0, 32'h0, 1'b0, 32'h0};
      tbl[2] = '{SEL_ADD4, 1'b1, 32'h0, 1'b0, 32'h0};
      tbl[3] = '{SEL_ADD4, 1'b0, 32'h0, 1'b0, 32'h0};
      tbl[4] = '{SEL_ADD4, 1'b1, 32'h4, 1'b1, 32'h0};
      tbl[5] = '{SEL_ADD4, 1'b0, 32'h4, 1'b0, 32'h0};
      tbl[6] = '{SEL_ADD4, 1'b1, 32'h8, 1'b1, 32'h4};
      tbl[7] = '{SEL_ADD4, 1'b0, 32'h8, 1'b0, 32'h4};
      tbl[8] = '{SEL_ADD4, 1'b1, 32'hC, 1'b1, 32'h8};

      // Start-up stream, 1-cycle memory, decode always ready.
      reset_dut();
      push_exp(32'h0, 3);
      for (int k = 0; k < 9; k++) begin
         pc_sel = tbl[k].sel;
         smp();
         chk($sformatf("t1_req[%0d]", k), 32'(if0.imem_req_o), 32'(tbl[k].req));
         chk($sformatf("t1_addr[%0d]", k), if0.imem_addr_o, tbl[k].addr);
         chk($sformatf("t1_valid[%0d]", k), 32'(if0.ir_valid_o), 32'(tbl[k].valid));
         chk($sformatf("t1_pc[%0d]", k), if0.pc_o, tbl[k].pc);
         cyc();
      end
      chk("t1_drain", 32'(exp_q.size()), 32'h0);
      if0.ir_ready_i = 1'b0;
      if (glog2.size() >= 2) begin
         chk("t5_wrap_first", glog2[0], 32'hFFFF_FFFC);
         chk("t5_wrap_second", glog2[1], 32'h0000_0000);
      end else begin
         chk("t5_wrap_count", 32'(glog2.size()), 32'h2);
      end

      // Decode back-pressure for 5 cycles while streaming.
      reset_dut();
      push_exp(32'h0, 5);
      smp();
      cyc();
      pc_sel = SEL_ADD4;
      n0 = 0;
      do begin
         smp();
         seen = if0.ir_valid_o;
         cyc();
         n0++;
      end while (!seen && n0 < 50);
      chk("t2_first_valid", 32'(seen), 32'h1);
      if0.ir_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         smp();
         chk("t2_no_req", 32'(if0.imem_req_o), 32'h0);
         if (i >= 1) begin
            chk("t2_held_valid", 32'(if0.ir_valid_o), 32'h1);
            chk("t2_held_pc", if0.pc_o, 32'h4);
         end
         cyc();
      end
      if0.ir_ready_i = 1'b1;
      wait_drain("t2_drain");

      // Jump while waiting on the response for 0x8.
      reset_dut();
      lat = 3;
      push_exp(32'h0, 2);
      push_exp(32'h100, 2);
      smp();
      cyc();
      pc_sel = SEL_ADD4;
      wait_grant(32'h0, "t3_g0");
      wait_grant(32'h4, "t3_g4");
      wait_grant(32'h8, "t3_g8");
      pc_sel = SEL_JUMP;
      next_pc = 32'h100;
      smp();
      cyc();
      pc_sel = SEL_ADD4;
      n0 = glog.size();
      for (int n = 0; n < 40; n++) begin
         smp();
         chk("t3_valid_low", 32'(if0.ir_valid_o), 32'h0);
         if (glog.size() != n0) break;
         cyc();
      end
      if (glog.size() == n0) chk("t3_g100_timeout", 32'h0, 32'h1);
      else chk("t3_g100", glog[n0], 32'h100);
      cyc();
      wait_drain("t3_drain");

      // Branch not taken keeps streaming; taken together with rvalid drops data.
      reset_dut();
      push_exp(32'h0, 2);
      push_exp(32'h40, 2);
      smp();
      cyc();
      pc_sel = SEL_BRANCH;
      br_taken = 1'b0;
      next_pc = 32'h40;
      wait_grant(32'h0, "t4_g0");
      wait_grant(32'h4, "t4_g4");
      wait_grant(32'h8, "t4_g8");
      br_taken = 1'b1;
      smp();
      cyc();
      br_taken = 1'b0;
      wait_grant(32'h40, "t4_g40");
      wait_drain("t4_drain");

      // Stall holds off the request; an ungranted request keeps its address.
      reset_dut();
      push_exp(32'h0, 2);
      stall = 1'b1;
      smp();
      cyc();
      pc_sel = SEL_ADD4;
      smp();
      cyc();
      for (int i = 0; i < 3; i++) begin
         smp();
         chk("t5_stall_req", 32'(if0.imem_req_o), 32'h0);
         chk("t5_stall_addr", if0.imem_addr_o, 32'h0);
         cyc();
      end
      stall = 1'b0;
      if0.imem_gnt_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         smp();
         chk("t5_nognt_req", 32'(if0.imem_req_o), 32'h1);
         chk("t5_nognt_addr", if0.imem_addr_o, 32'h0);
         cyc();
      end
      if0.imem_gnt_i = 1'b1;
      wait_grant(32'h0, "t5_g0");
      wait_drain("t5_drain");

      // Misaligned redirect target.
      reset_dut();
      smp();
      cyc();
      pc_sel = SEL_JUMP;
      next_pc = 32'h102;
`ifdef FETCH_MISALIGN_CHECK_EN
      smp();
      cyc();
      pc_sel = SEL_ADD4;
      for (int i = 0; i < 3; i++) begin
         smp();
         chk("t6_flag_set", 32'(misalign), 32'h1);
         chk("t6_no_req", 32'(if0.imem_req_o), 32'h0);
         cyc();
      end
      pc_sel = SEL_JUMP;
      next_pc = 32'h200;
      push_exp(32'h200, 2);
      smp();
      cyc();
      pc_sel = SEL_ADD4;
      smp();
      chk("t6_flag_clr", 32'(misalign), 32'h0);
      chk("t6_req", 32'(if0.imem_req_o), 32'h1);
      chk("t6_addr", if0.imem_addr_o, 32'h200);
      cyc();
      wait_drain("t6_drain");
`else
      push_exp(32'h100, 2);
      smp();
      cyc();
      pc_sel = SEL_ADD4;
      wait_grant(32'h100, "t6_align");
      wait_drain("t6_drain");
`endif

      // Reset while waiting on a response, then a clean restart.
      reset_dut();
      lat = 3;
      smp();
      cyc();
      pc_sel = SEL_ADD4;
      wait_grant(32'h0, "t7_g0");
      reset_dut();
      push_exp(32'h0, 2);
      smp();
      cyc();
      pc_sel = SEL_ADD4;
      wait_drain("t7_drain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
